reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 2: consecutive contended cycles port B may lose before it gets priority (range 1..3).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port a_req  input  1  pipeline writeback request, held until acked.
REQ-005 SHALL have port a_addr  input  5  pipeline destination register.
REQ-006 SHALL have port a_data  input  32  pipeline write data.
REQ-007 SHALL have port a_ack  output  1  combinational grant to A in the current cycle.
REQ-008 SHALL have port b_req  input  1  bus-load return request, held until acked.
REQ-009 SHALL have port b_addr  input  5  load destination register.
REQ-010 SHALL have port b_data  input  32  load return data.
REQ-011 SHALL have port b_ack  output  1  combinational grant to B in the current cycle.
REQ-012 SHALL have port ld_issue  input  1  a bus load is issued this cycle.
REQ-013 SHALL have port ld_rd  input  5  destination of the issued load.
REQ-014 SHALL have port rs1  input  5  decode-stage source register 1.
REQ-015 SHALL have port rs2  input  5  decode-stage source register 2.
REQ-016 SHALL have port hazard  output  1  combinational: a source register awaits a load.
REQ-017 SHALL have port RegWrite  output  1  registered write enable to the register file.
REQ-018 SHALL have port WriteRegister  output  5  registered write address.
REQ-019 SHALL have port WriteData  output  32  registered write data.

Function
REQ-020 SHALL grant at most one of a_ack/b_ack per cycle; a requester's transfer completes at the rising edge where its ack is high.
REQ-021 SHALL grant A when only a_req is high, and B when only b_req is high.
REQ-022 SHALL, when both requests are high, grant A unless wait_b == STARVE_LIMIT, in which case grant B.
REQ-023 SHALL keep a 2-bit wait_b counter: +1 (saturating at STARVE_LIMIT) each edge where b_req=1 and b_ack=0; cleared to 0 on a B grant or when b_req=0.
REQ-024 SHALL, one edge after a grant, drive RegWrite=1 with the granted addr/data on WriteRegister/WriteData; with no grant, RegWrite=0 and WriteRegister/WriteData hold their previous values.
REQ-025 SHALL ack a granted request whose address is 0 but drive RegWrite=0 for it (register 0 is never written).
REQ-026 SHALL keep pending[31:0]; ld_issue sets pending[ld_rd]; a B grant clears pending[b_addr]; index 0 is never set.
REQ-027 SHALL, when set and clear target the same index on the same edge, leave the bit set (the new load wins).
REQ-028 SHALL drive hazard = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]), from registered state only.
REQ-029 SHALL accept an A grant to a register with its pending bit set without altering the bit (the load write still follows).
REQ-030 SHALL keep latency grant->RegWrite at exactly one cycle so the register file's falling-edge write sees stable address/data.

Reset
REQ-031 SHALL, while reset is high, force RegWrite=0, WriteRegister=0, WriteData=0, wait_b=0, pending=0, independent of clk.
REQ-032 SHALL force a_ack=b_ack=0 while reset is high; a request in flight at reset is not acked and is presented again by its requester.
REQ-033 SHALL begin normal arbitration at the first rising edge after reset falls.

Verification
REQ-034 SHALL pass: a_req only, a_addr=5, a_data=0xDEADBEEF -> a_ack same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF.
REQ-035 SHALL pass: a_req and b_req held high continuously, STARVE_LIMIT=2 -> grants A, A, B, A, A, B; RegWrite high every cycle after the first.
REQ-036 SHALL pass: ld_issue with ld_rd=7, then rs1=7 -> hazard=1 next cycle; B grant with b_addr=7 -> hazard=0 the cycle after.
REQ-037 SHALL pass: ld_issue with ld_rd=9 on the same edge as a B grant with b_addr=9 -> pending[9] stays 1 and hazard stays 1 for rs2=9.
REQ-038 SHALL pass: a_req with a_addr=0 -> a_ack=1, RegWrite stays 0; ld_issue with ld_rd=0 -> pending unchanged and hazard=0.
REQ-039 SHALL pass: reset asserted mid-cycle while b_req is pending and pending[3]=1 -> outputs and pending read 0 immediately, b_ack=0 until reset falls.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: the pipeline (A) and bus-load returns (B) share one
// write port, with B starvation protection and a pending-load scoreboard driving hazard.
module reg_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ack,
   input  logic        ld_issue,
   input  logic [4:0]  ld_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard,
   output logic        RegWrite,
   output logic [4:0]  WriteRegister,
   output logic [31:0] WriteData
);

   localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

   logic [1:0]  waitB;
   logic [31:0] pending;
   logic [31:0] pendingNext;
   logic        bPriority;

   always_comb begin
      bPriority = (waitB == LIMIT);
      a_ack     = 1'b0;
      b_ack     = 1'b0;
      if (!reset) begin
         if (a_req && (!b_req || !bPriority)) begin
            a_ack = 1'b1;
         end else if (b_req) begin
            b_ack = 1'b1;
         end
      end
   end

   // The set is applied after the clear so a new load to the same register wins.
   always_comb begin
      pendingNext = pending;
      if (b_ack) begin
         pendingNext[b_addr] = 1'b0;
      end
      if (ld_issue && (ld_rd != '0)) begin
         pendingNext[ld_rd] = 1'b1;
      end
   end

   always_comb begin
      hazard = ((rs1 != '0) && pending[rs1]) || ((rs2 != '0) && pending[rs2]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
         waitB         <= '0;
         pending       <= '0;
      end else begin
         RegWrite <= 1'b0;
         if (a_ack) begin
            RegWrite      <= (a_addr != '0);
            WriteRegister <= a_addr;
            WriteData     <= a_data;
         end else if (b_ack) begin
            RegWrite      <= (b_addr != '0);
            WriteRegister <= b_addr;
            WriteData     <= b_data;
         end

         if (b_ack || !b_req) begin
            waitB <= '0;
         end else if (waitB != LIMIT) begin
            waitB <= waitB + 2'd1;
         end

         pending <= pendingNext;
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: acks and hazard are checked mid-cycle, and the
// expected writeback is queued then popped one edge later.
module tb_reg_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        a_req;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        a_ack;
   logic        b_req;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        b_ack;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;

   typedef struct packed {
      logic        rw;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         sb[$];
   logic [4:0]  lastAddr;
   logic [31:0] lastData;
   int          errors = 0;
   int          checks = 0;

   reg_wb_arbiter #(.STARVE_LIMIT(2)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the current inputs: acks/hazard checked at the falling edge,
   // the writeback this cycle should cause is queued, then checked after the rising edge.
   task automatic cycle(input string tag, input logic eA, input logic eB, input logic eH);
      wr_t e;
      wr_t got;
      @(negedge clk);
      check({tag, ".a_ack"}, a_ack, eA);
      check({tag, ".b_ack"}, b_ack, eB);
      check({tag, ".hazard"}, hazard, eH);
      if (eA) begin
         e = '{rw: (a_addr != 0), addr: a_addr, data: a_data};
      end else if (eB) begin
         e = '{rw: (b_addr != 0), addr: b_addr, data: b_data};
      end else begin
         e = '{rw: 1'b0, addr: lastAddr, data: lastData};
      end
      lastAddr = e.addr;
      lastData = e.data;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({tag, ".RegWrite"}, RegWrite, got.rw);
      check({tag, ".WriteRegister"}, WriteRegister, got.addr);
      check({tag, ".WriteData"}, WriteData, got.data);
   endtask

   initial begin
      reset = 1'b1;
      a_req = 0; a_addr = 0; a_data = 0;
      b_req = 0; b_addr = 0; b_data = 0;
      ld_issue = 0; ld_rd = 0; rs1 = 0; rs2 = 0;
      lastAddr = 0; lastData = 0;

      #2;
      check("rst.RegWrite", RegWrite, 1'b0);
      check("rst.WriteRegister", WriteRegister, 5'd0);
      check("rst.WriteData", WriteData, 32'd0);
      a_req = 1'b1; b_req = 1'b1;
      #1;
      check("rst.a_ack", a_ack, 1'b0);
      check("rst.b_ack", b_ack, 1'b0);
      @(posedge clk);
      #1;
      check("rst.RegWrite_edge", RegWrite, 1'b0);
      a_req = 1'b0; b_req = 1'b0;
      reset = 1'b0;

      cycle("idle", 0, 0, 0);

      // single A write and hold afterwards
      a_req = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
      cycle("aonly", 1, 0, 0);
      a_req = 0;
      cycle("hold", 0, 0, 0);

      // continuous contention: A, A, B repeating
      a_req = 1; a_addr = 5'd10; b_req = 1; b_addr = 5'd11; b_data = 32'hB0B0_0000;
      for (int i = 0; i < 6; i++) begin
         a_data = 32'hA000_0000 + 32'(i);
         cycle($sformatf("contend%0d", i), (i % 3) != 2, (i % 3) == 2, 0);
      end

      // dropping b_req resets the starvation count
      cycle("wclr0", 1, 0, 0);
      b_req = 0;
      cycle("wclr1", 1, 0, 0);
      b_req = 1;
      cycle("wclr2", 1, 0, 0);
      cycle("wclr3", 1, 0, 0);
      cycle("wclr4", 0, 1, 0);
      a_req = 0;
      b_addr = 5'd12; b_data = 32'h0000_BBBB;
      cycle("bonly", 0, 1, 0);
      b_req = 0;

      // load hazard set then cleared by B return
      ld_issue = 1; ld_rd = 5'd7;
      cycle("ld7", 0, 0, 0);
      ld_issue = 0; rs1 = 5'd7;
      cycle("haz7", 0, 0, 1);
      b_req = 1; b_addr = 5'd7; b_data = 32'h7777_7777;
      cycle("ret7", 0, 1, 1);
      b_req = 0;
      cycle("clr7", 0, 0, 0);
      rs1 = 0;

      // same-edge set and clear: the new load wins
      ld_issue = 1; ld_rd = 5'd9;
      cycle("ld9", 0, 0, 0);
      rs2 = 5'd9; b_req = 1; b_addr = 5'd9; b_data = 32'h9999_0001;
      cycle("setclr9", 0, 1, 1);
      ld_issue = 0; b_req = 0;
      cycle("keep9", 0, 0, 1);
      b_req = 1; b_data = 32'h9999_0002;
      cycle("ret9", 0, 1, 1);
      b_req = 0;
      cycle("clr9", 0, 0, 0);
      rs2 = 0;

      // A write to a register with a load outstanding leaves the pending bit alone
      ld_issue = 1; ld_rd = 5'd12;
      cycle("ld12", 0, 0, 0);
      ld_issue = 0; rs1 = 5'd12; a_req = 1; a_addr = 5'd12; a_data = 32'h1212_1212;
      cycle("a12", 1, 0, 1);
      a_req = 0;
      cycle("keep12", 0, 0, 1);
      b_req = 1; b_addr = 5'd12; b_data = 32'hC0C0_C0C0;
      cycle("ret12", 0, 1, 1);
      b_req = 0;
      cycle("clr12", 0, 0, 0);
      rs1 = 0;

      // register 0: acked but never written, never pending
      a_req = 1; a_addr = 5'd0; a_data = 32'h0000_1234;
      cycle("a0", 1, 0, 0);
      a_req = 0; ld_issue = 1; ld_rd = 5'd0;
      cycle("ld0", 0, 0, 0);
      ld_issue = 0;
      cycle("after0", 0, 0, 0);

      // mid-cycle reset with B waiting and a load outstanding
      ld_issue = 1; ld_rd = 5'd3;
      cycle("ld3", 0, 0, 0);
      ld_issue = 0; rs1 = 5'd3;
      a_req = 1; a_addr = 5'd4; a_data = 32'h4444_4444;
      b_req = 1; b_addr = 5'd5; b_data = 32'h5555_5555;
      cycle("prerst", 1, 0, 1);
      a_req = 0;
      #2;
      reset = 1'b1;
      #1;
      check("mrst.RegWrite", RegWrite, 1'b0);
      check("mrst.WriteRegister", WriteRegister, 5'd0);
      check("mrst.WriteData", WriteData, 32'd0);
      check("mrst.hazard", hazard, 1'b0);
      check("mrst.b_ack", b_ack, 1'b0);
      @(posedge clk);
      #1;
      check("mrst.b_ack_edge", b_ack, 1'b0);
      check("mrst.RegWrite_edge", RegWrite, 1'b0);
      reset = 1'b0;
      lastAddr = 0; lastData = 0;
      cycle("postrst", 0, 1, 0);
      b_req = 0; rs1 = 0;
      cycle("final", 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
